// File: rtl/core_mem_arbiter_if.sv
// Purpose: bundles the I, D and memory request/response signals of the core memory arbiter.
// Latency: wiring only, no storage.
// Backpressure: req_val is held until req_ack; responses have no backpressure.
interface core_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              i_req_val;
  logic              i_req_ack;
  logic              i_req_cop;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_req_wdata;
  logic              i_ack_val;
  logic [DATA_W-1:0] i_ack_rdata;
  // data requester
  logic              d_req_val;
  logic              d_req_ack;
  logic              d_req_cop;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_ack_val;
  logic [DATA_W-1:0] d_ack_rdata;
  // shared memory port
  logic              m_req_val;
  logic              m_req_ack;
  logic              m_req_cop;
  logic [ADDR_W-1:0] m_req_addr;
  logic [DATA_W-1:0] m_req_wdata;
  logic              m_ack_val;
  logic [DATA_W-1:0] m_ack_rdata;

  // arbiter side: serves the two requesters, drives the memory port
  modport slave (
    input  i_req_val, i_req_cop, i_req_addr, i_req_wdata,
    output i_req_ack, i_ack_val, i_ack_rdata,
    input  d_req_val, d_req_cop, d_req_addr, d_req_wdata,
    output d_req_ack, d_ack_val, d_ack_rdata,
    output m_req_val, m_req_cop, m_req_addr, m_req_wdata,
    input  m_req_ack, m_ack_val, m_ack_rdata
  );

  // environment side: the requesters and the memory
  modport master (
    output i_req_val, i_req_cop, i_req_addr, i_req_wdata,
    input  i_req_ack, i_ack_val, i_ack_rdata,
    output d_req_val, d_req_cop, d_req_addr, d_req_wdata,
    input  d_req_ack, d_ack_val, d_ack_rdata,
    input  m_req_val, m_req_cop, m_req_addr, m_req_wdata,
    output m_req_ack, m_ack_val, m_ack_rdata
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Purpose: round-robin share of one memory port between I-fetch and D requesters, in-order response routing.
// Latency: 0 cycles request->memory and response->requester (combinational paths).
// Backpressure: grant locked until m_req_ack; no new grant while MAX_OUT requests are outstanding.
module core_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4   // power of 2, at least 2
) (
  input  logic                     clk,
  input  logic                     rst,
  core_mem_arbiter_if.slave        bus,
  output logic [$clog2(MAX_OUT):0] outstanding,
  output logic                     err_unexp_ack
);
  localparam int PW = $clog2(MAX_OUT);

  // owner encoding used in the lock register, rr_last and the ID FIFO
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_t;

  lock_state_t   state;
  logic          lock_owner;
  logic          rr_last;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          id_mem [MAX_OUT];

  logic              owner;
  logic              win_val;
  logic              full;
  logic              empty;
  logic              accept;
  logic              pop;
  logic              head;
  logic              sel_cop;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign full  = (count == (PW+1)'(MAX_OUT));
  assign empty = (count == '0);

  // pick the owner: a locked grant sticks, otherwise a tie goes to whoever did not win last
  always_comb begin
    owner = OWN_I;
    if (state == ST_LOCKED) begin
      owner = lock_owner;
    end else if (bus.i_req_val && bus.d_req_val) begin
      owner = ~rr_last;
    end else if (bus.d_req_val) begin
      owner = OWN_D;
    end
  end

  assign win_val   = (owner == OWN_D) ? bus.d_req_val   : bus.i_req_val;
  assign sel_cop   = (owner == OWN_D) ? bus.d_req_cop   : bus.i_req_cop;
  assign sel_addr  = (owner == OWN_D) ? bus.d_req_addr  : bus.i_req_addr;
  assign sel_wdata = (owner == OWN_D) ? bus.d_req_wdata : bus.i_req_wdata;

  // a full ID FIFO blocks the memory request; the slot freed by a pop is only seen next cycle
  assign bus.m_req_val   = win_val & ~full;
  assign bus.m_req_cop   = sel_cop;
  assign bus.m_req_addr  = sel_addr;
  assign bus.m_req_wdata = sel_wdata;

  assign accept        = bus.m_req_val & bus.m_req_ack;
  assign bus.i_req_ack = accept & (owner == OWN_I);
  assign bus.d_req_ack = accept & (owner == OWN_D);

  // responses follow request order, so the FIFO head names the requester; stray responses are dropped
  assign pop             = bus.m_ack_val & ~empty;
  assign head            = id_mem[rd_ptr];
  assign bus.i_ack_val   = pop & (head == OWN_I);
  assign bus.d_ack_val   = pop & (head == OWN_D);
  assign bus.i_ack_rdata = bus.m_ack_rdata;
  assign bus.d_ack_rdata = bus.m_ack_rdata;

  assign outstanding = count;

  // lock FSM, round-robin history, FIFO pointers/occupancy and the sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_OPEN;
      lock_owner    <= OWN_I;
      rr_last       <= OWN_I;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_unexp_ack <= 1'b0;
    end else begin
      case (state)
        ST_OPEN: begin
          if (bus.m_req_val && !bus.m_req_ack) begin
            state      <= ST_LOCKED;
            lock_owner <= owner;
          end
        end
        ST_LOCKED: begin
          if (bus.m_req_ack) begin
            state <= ST_OPEN;
          end
        end
        default: state <= ST_OPEN;
      endcase

      if (accept) begin
        rr_last <= owner;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({accept, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase

      if (bus.m_ack_val && empty) begin
        err_unexp_ack <= 1'b1;
      end
    end
  end

  // ID storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (accept) begin
      id_mem[wr_ptr] <= owner;
    end
  end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Purpose: directed plus randomized checks of core_mem_arbiter against a queue-based reference model.
// Latency: inputs driven at negedge, outputs sampled 1 ns later, model advanced at posedge.
// Backpressure: requesters hold requests until acked; memory accept and responses are randomized.
module tb_core_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [$clog2(MO):0] outstanding;
  logic err_unexp_ack;

  always #5 clk = ~clk;

  core_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  core_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .outstanding   (outstanding),
    .err_unexp_ack (err_unexp_ack)
  );

  int tests = 0;
  int fails = 0;

  // reference model: owner queue (0 = I, 1 = D), lock, last winner, sticky error
  int q[$];
  bit lk, lk_own, rr, err_m;
  bit e_own, e_mval, e_acc, e_pop, e_head, e_unexp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    lk = 0; lk_own = 0; rr = 0; err_m = 0;
  endtask

  task automatic drv_i(input bit v, input bit cop, input logic [AW-1:0] a, input logic [DW-1:0] w);
    bus.i_req_val = v; bus.i_req_cop = cop; bus.i_req_addr = a; bus.i_req_wdata = w;
  endtask

  task automatic drv_d(input bit v, input bit cop, input logic [AW-1:0] a, input logic [DW-1:0] w);
    bus.d_req_val = v; bus.d_req_cop = cop; bus.d_req_addr = a; bus.d_req_wdata = w;
  endtask

  task automatic mem(input bit rack, input bit aval, input logic [DW-1:0] rd);
    bus.m_req_ack = rack; bus.m_ack_val = aval; bus.m_ack_rdata = rd;
  endtask

  // compare every output against what the arbitration and routing rules predict
  task automatic chk_now();
    bit iv, dv;
    #1;
    iv = bus.i_req_val;
    dv = bus.d_req_val;
    if (lk)            e_own = lk_own;
    else if (iv && dv) e_own = !rr;
    else               e_own = dv;
    e_mval  = (e_own ? dv : iv) && (q.size() < MO);
    e_acc   = e_mval && bus.m_req_ack;
    e_pop   = bus.m_ack_val && (q.size() > 0);
    e_unexp = bus.m_ack_val && (q.size() == 0);
    e_head  = (q.size() > 0) ? (q[0] == 1) : 1'b0;
    chk("m_req_val", bus.m_req_val, e_mval);
    if (e_mval) begin
      chk("m_req_addr",  bus.m_req_addr,  e_own ? bus.d_req_addr  : bus.i_req_addr);
      chk("m_req_cop",   bus.m_req_cop,   e_own ? bus.d_req_cop   : bus.i_req_cop);
      chk("m_req_wdata", bus.m_req_wdata, e_own ? bus.d_req_wdata : bus.i_req_wdata);
    end
    chk("i_req_ack", bus.i_req_ack, e_acc && !e_own);
    chk("d_req_ack", bus.d_req_ack, e_acc && e_own);
    chk("i_ack_val", bus.i_ack_val, e_pop && !e_head);
    chk("d_ack_val", bus.d_ack_val, e_pop && e_head);
    if (e_pop)
      chk(e_head ? "d_ack_rdata" : "i_ack_rdata",
          e_head ? bus.d_ack_rdata : bus.i_ack_rdata, bus.m_ack_rdata);
    chk("outstanding", outstanding, q.size());
    chk("err_unexp_ack", err_unexp_ack, err_m);
  endtask

  task automatic adv();
    @(posedge clk);
    if (e_mval && !e_acc) begin lk = 1; lk_own = e_own; end
    if (e_acc) begin lk = 0; rr = e_own; end
    if (e_unexp) err_m = 1;
    if (e_pop) void'(q.pop_front());
    if (e_acc) q.push_back(e_own);
    @(negedge clk);
  endtask

  task automatic cyc();
    chk_now();
    adv();
  endtask

  task automatic idle_all();
    drv_i(0, 0, '0, '0);
    drv_d(0, 0, '0, '0);
    mem(0, 0, '0);
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_unexp_ack, 0);
    chk("rst_m_req_val", bus.m_req_val, 0);
    chk("rst_ack_vals", {bus.i_ack_val, bus.d_ack_val, bus.i_req_ack, bus.d_req_ack}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    mem(0, 0, '0);
    for (int n = 0; n < 3 * MO && q.size() > 0; n++) begin
      mem(0, 1, $urandom);
      cyc();
    end
    mem(0, 0, '0);
    chk("drain_empty", outstanding, 0);
  endtask

  initial begin
    int ia, da;
    idle_all();
    #2;
    do_reset();

    // single I read, response three cycles after accept
    drv_i(1, 0, 32'h100, 32'h0);
    mem(1, 0, '0);
    chk_now();
    chk("t1_iack", bus.i_req_ack, 1);
    chk("t1_addr", bus.m_req_addr, 32'h100);
    adv();
    drv_i(0, 0, '0, '0);
    mem(0, 0, '0);
    for (int k = 0; k < 2; k++) begin
      chk_now();
      chk("t1_out1", outstanding, 1);
      adv();
    end
    mem(0, 1, 32'hDEADBEEF);
    chk_now();
    chk("t1_iackv", bus.i_ack_val, 1);
    chk("t1_rdata", bus.i_ack_rdata, 32'hDEADBEEF);
    chk("t1_dackv", bus.d_ack_val, 0);
    adv();
    mem(0, 0, '0);
    chk_now();
    chk("t1_out0", outstanding, 0);
    adv();

    // both valid, memory always ready: D, I, D, I
    ia = 0; da = 0;
    mem(1, 0, '0);
    for (int k = 0; k < 4; k++) begin
      drv_i(1, 0, 32'h1000 + ia, 32'h0);
      drv_d(1, 1, 32'h2000 + da, 32'h5000 + da);
      chk_now();
      chk("t2_dgrant", bus.d_req_ack, (k % 2) == 0);
      chk("t2_igrant", bus.i_req_ack, (k % 2) == 1);
      adv();
      if (e_acc && e_own) da++;
      if (e_acc && !e_own) ia++;
    end
    drv_i(0, 0, '0, '0);
    drv_d(0, 0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      mem(0, 1, 32'hA0 + k);
      chk_now();
      chk("t2_dresp", bus.d_ack_val, (k % 2) == 0);
      chk("t2_iresp", bus.i_ack_val, (k % 2) == 1);
      adv();
    end

    // lock: make D the last winner, then a stalled D write must hold the port against I
    drv_d(1, 0, 32'h300, 32'h0);
    mem(1, 0, '0);
    cyc();
    drain();
    drv_d(1, 1, 32'h200, 32'hCAFE);
    mem(0, 0, '0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) drv_i(1, 0, 32'h400, 32'h0);
      chk_now();
      chk("t3_addr_hold", bus.m_req_addr, 32'h200);
      chk("t3_i_wait", bus.i_req_ack, 0);
      adv();
    end
    mem(1, 0, '0);
    chk_now();
    chk("t3_dacc", bus.d_req_ack, 1);
    adv();
    drv_d(0, 0, '0, '0);
    chk_now();
    chk("t3_iacc", bus.i_req_ack, 1);
    chk("t3_iaddr", bus.m_req_addr, 32'h400);
    adv();
    drv_i(0, 0, '0, '0);
    drain();

    // fill the ID FIFO, then a pop while full frees the slot one cycle later
    mem(1, 0, '0);
    for (int k = 0; k < MO; k++) begin
      drv_i(1, 0, 32'h800 + k, 32'h0);
      chk_now();
      chk("t4_fill", bus.i_req_ack, 1);
      adv();
    end
    drv_i(1, 0, 32'h900, 32'h0);
    chk_now();
    chk("t4_full_blk", bus.m_req_val, 0);
    chk("t4_full_out", outstanding, MO);
    adv();
    mem(1, 1, 32'h77);
    chk_now();
    chk("t4_pop_same", bus.m_req_val, 0);
    adv();
    mem(1, 0, '0);
    chk_now();
    chk("t4_next_acc", bus.i_req_ack, 1);
    adv();
    drv_i(0, 0, '0, '0);
    drain();

    // response with nothing outstanding
    mem(0, 1, 32'h55);
    chk_now();
    chk("t5_no_ackv", {bus.i_ack_val, bus.d_ack_val}, 0);
    adv();
    mem(0, 0, '0);
    for (int k = 0; k < 3; k++) begin
      chk_now();
      chk("t5_err_sticky", err_unexp_ack, 1);
      adv();
    end

    // reset with two outstanding and a lock held on I
    mem(1, 0, '0);
    drv_i(1, 0, 32'hA00, 32'h0);
    cyc();
    drv_i(0, 0, '0, '0);
    drv_d(1, 0, 32'hB00, 32'h0);
    cyc();
    drv_d(0, 0, '0, '0);
    drv_i(1, 0, 32'hA04, 32'h0);
    mem(0, 0, '0);
    cyc();
    chk("t6_pre_out", outstanding, 2);
    drv_d(1, 0, 32'hB04, 32'h0);
    rst = 1'b1;
    model_reset();
    chk_now();
    chk("t6_rst_out", outstanding, 0);
    chk("t6_rst_unlock", bus.m_req_addr, 32'hB04);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drv_i(0, 0, '0, '0);
    drv_d(0, 0, '0, '0);
    mem(0, 1, 32'h99);
    chk_now();
    chk("t6_stale", {bus.i_ack_val, bus.d_ack_val}, 0);
    adv();
    drv_i(1, 0, 32'hA08, 32'h0);
    drv_d(1, 0, 32'hB08, 32'h0);
    mem(1, 0, '0);
    chk_now();
    chk("t6_tie_d", bus.d_req_ack, 1);
    chk("t6_err", err_unexp_ack, 1);
    adv();
    drv_d(0, 0, '0, '0);
    cyc();
    drv_i(0, 0, '0, '0);
    drain();
    do_reset();

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if (!bus.i_req_val && $urandom_range(1, 0) == 1)
        drv_i(1, 1'($urandom), $urandom, $urandom);
      if (!bus.d_req_val && $urandom_range(1, 0) == 1)
        drv_d(1, 1'($urandom), $urandom, $urandom);
      mem($urandom_range(99, 0) < 60,
          (q.size() > 0) && ($urandom_range(99, 0) < 45),
          $urandom);
      cyc();
      if (e_acc && !e_own) bus.i_req_val = 1'b0;
      if (e_acc && e_own)  bus.d_req_val = 1'b0;
    end
    drv_i(0, 0, '0, '0);
    drv_d(0, 0, '0, '0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
